priority_arbiter: RTL and testbench

PRIORITY_ARBITER -- requirements
Module: priority_arbiter

---
 rtl/priority_arbiter_if.sv | 16 +
 rtl/priority_arbiter.sv | 109 ++++++++++
 tb/tb_priority_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/priority_arbiter_if.sv
// Request/grant bundle for priority_arbiter: requesters drive req/mode,
// the arbiter returns the registered grant.
interface priority_arbiter_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned W = $clog2(N);

    logic [N-1:0] req;
    logic         mode;
    logic [W-1:0] gnt_idx;
    logic [N-1:0] gnt;
    logic         valid;

    modport master (output req, output mode, input gnt_idx, input gnt, input valid);
    modport slave  (input req, input mode, output gnt_idx, output gnt, output valid);
endinterface

// File: rtl/priority_arbiter.sv
// N-way arbiter with fixed-priority or round-robin selection, hold-until-release
// grants and optional round-robin pre-emption after MAX_HOLD cycles.
module priority_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    priority_arbiter_if.slave bus
);
    localparam int unsigned W        = $clog2(N);
    localparam logic [7:0]  HOLD_LIM = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t       state;
    logic [W-1:0] gnt_idx;
    logic [N-1:0] gnt;
    logic         valid;
    logic [W-1:0] ptr;
    logic [7:0]   hold_cnt;
    logic         mode_q;

    logic [N-1:0] others;
    logic [N-1:0] arb_req;
    logic [W-1:0] arb_win;
    logic         hold_own;
    logic         preempt;
    logic         issue;
    logic         release_gnt;

    // Highest set index wins.
    function automatic logic [W-1:0] fixed_pick(input logic [N-1:0] r);
        logic [W-1:0] win;
        win = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r[W'(i)]) win = W'(i);
        end
        return win;
    endfunction

    // Descending search starting just below the last grantee, wrapping at 0.
    function automatic logic [W-1:0] rr_pick(input logic [N-1:0] r, input logic [W-1:0] p);
        logic [W-1:0] win;
        logic         found;
        int unsigned  k;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            k = (32'(p) + N - i) % N;
            if (!found && r[W'(k)]) begin
                win   = W'(k);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // Re-arbitration from GRANT always excludes the current grantee.
    always_comb begin
        hold_own    = bus.req[gnt_idx];
        others      = bus.req & ~(N'(1) << gnt_idx);
        preempt     = (MAX_HOLD != 0) && mode_q && (hold_cnt == HOLD_LIM) && (|others);
        arb_req     = (state == IDLE) ? bus.req : others;
        arb_win     = bus.mode ? rr_pick(arb_req, ptr) : fixed_pick(arb_req);
        issue       = 1'b0;
        release_gnt = 1'b0;
        if (state == IDLE) begin
            issue = |bus.req;
        end else if (!hold_own) begin
            issue       = |others;
            release_gnt = ~(|others);
        end else begin
            issue = preempt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            gnt      <= '0;
            valid    <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
            mode_q   <= 1'b0;
        end else if (issue) begin
            state    <= GRANT;
            gnt_idx  <= arb_win;
            gnt      <= N'(1) << arb_win;
            valid    <= 1'b1;
            ptr      <= arb_win;
            hold_cnt <= '0;
            mode_q   <= bus.mode;
        end else if (release_gnt) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            gnt      <= '0;
            valid    <= 1'b0;
            hold_cnt <= '0;
        end else if ((state == GRANT) && (hold_cnt != 8'hFF)) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    assign bus.gnt_idx = gnt_idx;
    assign bus.gnt     = gnt;
    assign bus.valid   = valid;
endmodule

// File: tb/tb_priority_arbiter.sv
// Self-checking bench for priority_arbiter (N=4): directed vector table,
// hand-written corner sequences and random traffic against a reference model.
module tb_priority_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    priority_arbiter_if #(.N(4)) bus ();
    priority_arbiter_if #(.N(4)) bus0 ();

    priority_arbiter #(.N(4), .MAX_HOLD(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    priority_arbiter #(.N(4), .MAX_HOLD(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0] req;
        logic       mode;
        logic       exp_valid;
        logic [1:0] exp_idx;
    } vec_t;
    vec_t tbl[$];

    // Reference model state; instance 0 has MAX_HOLD=4, instance 1 has MAX_HOLD=0.
    int m_valid[2];
    int m_idx[2];
    int m_ptr[2];
    int m_cnt[2];
    int m_mode[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_valid[u] = 0; m_idx[u] = 0; m_ptr[u] = 0; m_cnt[u] = 0; m_mode[u] = 0;
        end
    endtask

    // One clock edge of the arbitration rules, from the spec's point of view.
    task automatic model_step(input int u, input logic [3:0] r, input logic md);
        int mh, excl;
        bit arb, found;
        int order[$];
        logic [3:0] rest;
        mh = (u == 0) ? 4 : 0;
        excl = -1;
        arb = 0;
        if (m_valid[u] == 0) begin
            arb = (r != 4'b0);
        end else if (r[m_idx[u]] == 1'b0) begin
            if (r != 4'b0) arb = 1;
            else begin m_valid[u] = 0; m_idx[u] = 0; m_cnt[u] = 0; end
        end else begin
            rest = r & ~(4'b0001 << m_idx[u]);
            if (mh != 0 && m_mode[u] == 1 && m_cnt[u] == mh - 1 && rest != 4'b0) begin
                arb = 1;
                excl = m_idx[u];
            end else if (m_cnt[u] < 255) begin
                m_cnt[u]++;
            end
        end
        if (arb) begin
            if (md) begin
                for (int k = m_ptr[u] - 1; k >= 0; k--) order.push_back(k);
                for (int k = 3; k >= m_ptr[u]; k--) order.push_back(k);
            end else begin
                for (int k = 3; k >= 0; k--) order.push_back(k);
            end
            found = 0;
            foreach (order[j]) begin
                if (!found && r[order[j]] && order[j] != excl) begin
                    m_idx[u] = order[j];
                    found = 1;
                end
            end
            m_valid[u] = 1; m_ptr[u] = m_idx[u]; m_cnt[u] = 0; m_mode[u] = md;
        end
    endtask

    task automatic invariants();
        check("inv_gnt", 32'(bus.gnt), bus.valid ? 32'(4'b0001 << bus.gnt_idx) : 32'd0);
        check("inv0_gnt", 32'(bus0.gnt), bus0.valid ? 32'(4'b0001 << bus0.gnt_idx) : 32'd0);
        if (!bus.valid) check("inv_idle_idx", 32'(bus.gnt_idx), 32'd0);
        if (!bus0.valid) check("inv0_idle_idx", 32'(bus0.gnt_idx), 32'd0);
    endtask

    task automatic cycle(input logic [3:0] r, input logic md);
        bus.req = r; bus.mode = md; bus0.req = r; bus0.mode = md;
        @(posedge clk);
        model_step(0, r, md);
        model_step(1, r, md);
        #1;
        invariants();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = '0; bus.mode = 1'b0; bus0.req = '0; bus0.mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_idx", 32'(bus.gnt_idx), 32'd0);
        check("rst0_valid", 32'(bus0.valid), 32'd0);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic add(input logic [3:0] r, input logic m, input logic v, input int idx);
        vec_t e;
        e.req = r; e.mode = m; e.exp_valid = v; e.exp_idx = 2'(idx);
        tbl.push_back(e);
    endtask

    task automatic expect_dut(input string name, input logic v, input int idx);
        check({name, "_valid"}, 32'(bus.valid), 32'(v));
        check({name, "_idx"}, 32'(bus.gnt_idx), 32'(idx));
        check({name, "_gnt"}, 32'(bus.gnt), v ? 32'(4'b0001 << idx) : 32'd0);
    endtask

    int exp30[9] = '{3, 3, 3, 3, 1, 1, 1, 1, 3};
    logic [3:0] cur;
    logic       md;

    initial begin
        // Round-robin rotation with each grantee dropping once (ptr starts at 0).
        add(4'b1111, 1, 1, 3); add(4'b0111, 1, 1, 2); add(4'b1011, 1, 1, 1);
        add(4'b1101, 1, 1, 0); add(4'b1110, 1, 1, 3); add(4'b0000, 1, 0, 0);
        // Fixed priority basic grant and release.
        add(4'b1100, 0, 1, 3); add(4'b0000, 0, 0, 0);
        // Fixed mode never pre-empts a held grant.
        add(4'b0001, 0, 1, 0); add(4'b0001, 0, 1, 0);
        for (int i = 0; i < 6; i++) add(4'b0101, 0, 1, 0);
        add(4'b0100, 0, 1, 2);
        // Requests seen during a grant are not remembered.
        add(4'b0110, 0, 1, 2); add(4'b0000, 0, 0, 0);
        // Mode flip while holding does not disturb the grant.
        add(4'b1010, 0, 1, 3);
        for (int i = 0; i < 6; i++) add(4'b1010, 1, 1, 3);
        add(4'b0000, 1, 0, 0);

        do_reset();
        foreach (tbl[i]) begin
            cycle(tbl[i].req, tbl[i].mode);
            expect_dut($sformatf("vec%0d", i), tbl[i].exp_valid, int'(tbl[i].exp_idx));
        end

        // Round-robin pre-emption after MAX_HOLD cycles; MAX_HOLD=0 never pre-empts.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(4'b1010, 1'b1);
            if (i < 9) check($sformatf("preempt%0d_idx", i), 32'(bus.gnt_idx), 32'(exp30[i]));
            check($sformatf("nohold%0d_idx", i), 32'(bus0.gnt_idx), 32'd3);
        end

        // Sole requester in round-robin keeps its grant.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(4'b0010, 1'b1);
        expect_dut("sole", 1'b1, 1);

        // Asynchronous reset mid-grant, then fresh arbitration.
        do_reset();
        cycle(4'b0100, 1'b0);
        expect_dut("pre_rst", 1'b1, 2);
        #1 rst_n = 1'b0;
        #1;
        expect_dut("async_rst", 1'b0, 0);
        model_reset();
        #2 rst_n = 1'b1;
        cycle(4'b0100, 1'b0);
        expect_dut("post_rst", 1'b1, 2);

        // Random traffic, one mode per phase, compared against the model.
        do_reset();
        cur = '0;
        for (int p = 0; p < 8; p++) begin
            md = 1'($urandom_range(0, 1));
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 3) == 0) cur = 4'($urandom);
                cycle(cur, md);
                check("rnd_valid", 32'(bus.valid), 32'(m_valid[0]));
                check("rnd_idx", 32'(bus.gnt_idx), 32'(m_idx[0]));
                check("rnd0_valid", 32'(bus0.valid), 32'(m_valid[1]));
                check("rnd0_idx", 32'(bus0.gnt_idx), 32'(m_idx[1]));
            end
            cur = '0;
            cycle(cur, md);
            cycle(cur, md);
            check("rnd_drain", 32'(bus.valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
